// File: rtl/multi_cycle_sub_add.sv
// Iterative WIDTH-bit add/subtract, SLICE bits per clock, START/DONE handshake.
// Optional ZERO/OVF flag outputs when MULTI_CYCLE_SUB_ADD_FLAGS_EN is defined.
module multi_cycle_sub_add #(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             START,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             B_CIN,
    input  logic             SUB_ADD,
    output logic [WIDTH-1:0] D_S,
    output logic             B_COUT,
    output logic             BUSY,
    output logic             DONE
`ifdef MULTI_CYCLE_SUB_ADD_FLAGS_EN
    ,
    output logic             ZERO,
    output logic             OVF
`endif
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int IW = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    generate
        if (SLICE < 1 || SLICE > WIDTH || (WIDTH % SLICE) != 0) begin : g_bad_cfg
            $error("multi_cycle_sub_add: WIDTH must be a multiple of SLICE");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic              sub_q, sub_d;
    logic              c_q, c_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [WIDTH-1:0]  acc_q, acc_d;
    logic [WIDTH-1:0]  d_s_q, d_s_d;
    logic              b_cout_q, b_cout_d;

    logic [SLICE-1:0]  a_sl;
    logic [SLICE-1:0]  b_sl;
    logic [SLICE:0]    sum;

`ifdef MULTI_CYCLE_SUB_ADD_FLAGS_EN
    logic              zero_q, zero_d;
    logic              ovf_q, ovf_d;
    logic              msb_cin;
`endif

    // Subtract is A + ~B + ~borrow_in; the carry register holds the inverted borrow.
    always_comb begin
        a_sl = a_q[idx_q*SLICE +: SLICE];
        b_sl = b_q[idx_q*SLICE +: SLICE] ^ {SLICE{sub_q}};
        sum  = {1'b0, a_sl} + {1'b0, b_sl} + {{SLICE{1'b0}}, c_q};
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        sub_d    = sub_q;
        c_d      = c_q;
        idx_d    = idx_q;
        acc_d    = acc_q;
        d_s_d    = d_s_q;
        b_cout_d = b_cout_q;
`ifdef MULTI_CYCLE_SUB_ADD_FLAGS_EN
        zero_d   = zero_q;
        ovf_d    = ovf_q;
        msb_cin  = a_sl[SLICE-1] ^ b_sl[SLICE-1] ^ sum[SLICE-1];
`endif
        unique case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (START) begin
                    state_d = S_RUN;
                    a_d     = A;
                    b_d     = B;
                    sub_d   = SUB_ADD;
                    c_d     = SUB_ADD ? ~B_CIN : B_CIN;
                    idx_d   = '0;
                end
            end
            S_RUN: begin
                acc_d[idx_q*SLICE +: SLICE] = sum[SLICE-1:0];
                c_d = sum[SLICE];
                if (idx_q == IW'(NSLICE - 1)) begin
                    state_d  = S_DONE;
                    d_s_d    = acc_d;
                    b_cout_d = sub_q ? ~sum[SLICE] : sum[SLICE];
`ifdef MULTI_CYCLE_SUB_ADD_FLAGS_EN
                    zero_d   = (acc_d == '0);
                    ovf_d    = msb_cin ^ sum[SLICE];
`endif
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            sub_q    <= 1'b0;
            c_q      <= 1'b0;
            idx_q    <= '0;
            acc_q    <= '0;
            d_s_q    <= '0;
            b_cout_q <= 1'b0;
`ifdef MULTI_CYCLE_SUB_ADD_FLAGS_EN
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sub_q    <= sub_d;
            c_q      <= c_d;
            idx_q    <= idx_d;
            acc_q    <= acc_d;
            d_s_q    <= d_s_d;
            b_cout_q <= b_cout_d;
`ifdef MULTI_CYCLE_SUB_ADD_FLAGS_EN
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
`endif
        end
    end

    assign D_S    = d_s_q;
    assign B_COUT = b_cout_q;
    assign BUSY   = (state_q == S_RUN);
    assign DONE   = (state_q == S_DONE);
`ifdef MULTI_CYCLE_SUB_ADD_FLAGS_EN
    assign ZERO   = zero_q;
    assign OVF    = ovf_q;
`endif

endmodule
